// File: rtl/cw_seq_pkg.sv
// Purpose : shared types/constants for the control-word sequencer.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: sequencer state encoding (observable on state_o) and the default NOP word.
package cw_seq_pkg;

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cw_state_e;

  localparam logic [15:0] NOP_CW_DEFAULT = 16'h0000;

endpackage

// File: rtl/edge_detect.sv
// Purpose : 1-bit rising-edge detector for a debounced button level.
// Latency : pulse is combinational from level and the registered previous sample.
// Backpr. : none; a held level yields exactly one pulse.
// Ports   : clk, reset_b (async active-low), level (debounced input), pulse (level & ~prev).
module edge_detect (
  input  logic clk,
  input  logic reset_b,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) prev <= 1'b0;
    else          prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/cw_sequencer.sv
// Purpose : DEPTH-entry control-word program buffer; issues words to Datapath by run or step.
// Latency : action taken on the edge where a button is first sampled high; outputs registered.
// Backpr. : none; loads into a full buffer and events in the wrong state are dropped.
// Ports   : clk, reset_b, cw_in, load_i/clear_i/run_i/step_i/halt_i (debounced levels),
//           control_word_o, cw_valid_o, pc_o, count_o, full_o, state_o.
// Build   : define CW_SEQ_LOOP_EN to make RUN wrap to index 0 instead of ending in DONE.
module cw_sequencer
  import cw_seq_pkg::*;
#(
  parameter int              CW_W   = 16,
  parameter int              DEPTH  = 8,
  parameter logic [CW_W-1:0] NOP_CW = CW_W'(NOP_CW_DEFAULT),
  localparam int             PTR_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [CW_W-1:0]  cw_in,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             halt_i,
  output logic [CW_W-1:0]  control_word_o,
  output logic             cw_valid_o,
  output logic [PTR_W-1:0] pc_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic [1:0]       state_o
);

  // ---------------- button edge detection ----------------
  logic [4:0] btn_level;
  logic [4:0] btn_edge;
  logic       clr_e, halt_e, load_e, run_e, step_e;

  assign btn_level = {clear_i, halt_i, load_i, run_i, step_i};

  for (genvar g = 0; g < 5; g++) begin : g_edge
    edge_detect u_edge (
      .clk     (clk),
      .reset_b (reset_b),
      .level   (btn_level[g]),
      .pulse   (btn_edge[g])
    );
  end

  assign {clr_e, halt_e, load_e, run_e, step_e} = btn_edge;

  // ---------------- state ----------------
  cw_state_e       state_q, state_d;
  logic [PTR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [CW_W-1:0]  cw_q, cw_d;
  logic             vld_q, vld_d;
  logic             wr_en;

  logic [CW_W-1:0]  mem [DEPTH];

  logic             full;
  logic             has_words;
  logic             last;
  logic             issue;
  cw_state_e        issue_state;

  assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
  assign has_words = (cnt_q != '0);
  // pc points at the final stored word; issuing it ends the program pass.
  assign last      = ({1'b0, pc_q} == (cnt_q - (PTR_W+1)'(1)));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      cw_q    <= NOP_CW;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      cw_q    <= cw_d;
      vld_q   <= vld_d;
    end
  end

  // Buffer storage carries no reset; contents are meaningless until loaded.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= cw_in;
  end

  // Event priority: clear > halt > load > run > step. While in RUN only clear
  // and halt are honoured; otherwise RUN keeps issuing one word per clock.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    cw_d        = NOP_CW;
    vld_d       = 1'b0;
    wr_en       = 1'b0;
    issue       = 1'b0;
    issue_state = state_q;

    if (clr_e) begin
      state_d = ST_IDLE;
      pc_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      if (halt_e) begin
        // The word on the output now is already issued; pc keeps the next index.
        state_d = ST_IDLE;
      end else begin
        issue       = 1'b1;
        issue_state = ST_RUN;
      end
    end else if (load_e) begin
      // A load into a full buffer is dropped entirely (no wrap, no state change).
      if (!full) begin
        wr_en   = 1'b1;
        wr_d    = wr_q + PTR_W'(1);
        cnt_d   = cnt_q + (PTR_W+1)'(1);
        state_d = ST_IDLE;
      end
    end else if (run_e && has_words) begin
      issue       = 1'b1;
      issue_state = ST_RUN;
    end else if (step_e && has_words) begin
      issue       = 1'b1;
      issue_state = ST_IDLE;
    end

    if (issue) begin
      cw_d  = mem[pc_q];
      vld_d = 1'b1;
      if (last) begin
        pc_d = '0;
`ifdef CW_SEQ_LOOP_EN
        state_d = (issue_state == ST_RUN) ? ST_RUN : ST_DONE;
`else
        state_d = ST_DONE;
`endif
      end else begin
        pc_d    = pc_q + PTR_W'(1);
        state_d = issue_state;
      end
    end
  end

  assign control_word_o = cw_q;
  assign cw_valid_o     = vld_q;
  assign pc_o           = pc_q;
  assign count_o        = cnt_q;
  assign full_o         = full;
  assign state_o        = state_q;

endmodule

// File: doc/cw_sequencer.md
Name: cw_sequencer

Overview:
Parametrised control-word program buffer and sequencer. Successor to the single-word "load on start" front end of the lab datapath top level. Holds up to DEPTH control words entered from switches, then issues them to Datapath either one per clock (run) or one per button press (step). Sits between the debounced button/switch inputs and the Datapath control_word port.

Parameters:
CW_W, 16, control word width (matches Datapath control_word)
DEPTH, 8, program buffer entries (power of 2, >=2)
NOP_CW, 0, word driven on control_word_o when no word is being issued
PTR_W, $clog2(DEPTH), pointer/pc width (derived, not overridden)

Ports:
clk  in  1  system clock
reset_b  in  1  asynchronous active-low reset
cw_in  in  CW_W  control word from switches
load_i  in  1  debounced level; rising edge writes cw_in into buffer
clear_i  in  1  debounced level; rising edge empties buffer
run_i  in  1  debounced level; rising edge starts/resumes continuous issue
step_i  in  1  debounced level; rising edge issues exactly one word
halt_i  in  1  debounced level; rising edge pauses RUN
control_word_o  out  CW_W  word to Datapath; NOP_CW when cw_valid_o=0
cw_valid_o  out  1  control_word_o holds a program word this cycle
pc_o  out  PTR_W  index of next word to issue
count_o  out  PTR_W+1  words currently stored
full_o  out  1  count_o==DEPTH
state_o  out  2  IDLE=0, RUN=1, DONE=2

Behaviour:
- Reset (async, reset_b=0): state IDLE, pc=0, wr_ptr=0, count=0, control_word_o=NOP_CW, cw_valid_o=0, full_o=0; edge-detector history regs cleared to 0; buffer contents undefined.
- Every *_i input is rising-edge detected internally: edge = in & ~prev, prev registered each clk. A held level produces one event.
- Action registered on the clock edge where edge=1; cw_valid_o/control_word_o change on that same edge, i.e. visible the cycle after the first high sample.
- Same-cycle priority: clear > halt > load > run > step. Lower-priority events that cycle are dropped.
- clear: any state -> IDLE; count=0, wr_ptr=0, pc=0, cw_valid_o=0.
- load (IDLE or DONE only; ignored in RUN): if !full, mem[wr_ptr]<=cw_in, wr_ptr++, count++. If full: ignored, no wrap. Load in DONE -> IDLE, pc unchanged.
- step (IDLE or DONE, count>0): issue mem[pc] for exactly one cycle (cw_valid_o=1), pc++. Issuing index count-1 -> DONE, pc=0. Step in DONE restarts at index 0. count==0: ignored.
- run (IDLE or DONE, count>0): enter RUN. Issue mem[pc] every cycle, pc++, cw_valid_o=1 each cycle. After issuing index count-1 -> DONE, pc=0, cw_valid_o=0 next cycle. run in DONE restarts at 0. run in RUN ignored.
- halt in RUN: -> IDLE. Word already on output this cycle counts as issued; pc keeps the next index; a later run/step resumes there. halt outside RUN: ignored.
- count==1: run issues one word, then DONE.
- All outputs registered; no combinational path from inputs to outputs.

Optional Feature:
CW_SEQ_LOOP_EN. Defined: in RUN, after index count-1, pc wraps to 0 and issue continues without a gap until halt or clear; DONE is reachable only via step. Undefined: RUN always terminates in DONE as above.

Decomposition:
- Package cw_seq_pkg: state enum (IDLE/RUN/DONE, 2-bit encoding as above), NOP_CW default constant.
- Sub-module edge_detect (1-bit rising-edge detector, async active-low reset); instantiated once per button input.
- Buffer is inferred registers inside cw_sequencer.

Test Plan:
- Reset mid-RUN: assert reset_b=0 while issuing -> next sample control_word_o=16'h0000, cw_valid_o=0, state_o=0, count_o=0.
- Load 16'hA001,16'hB002,16'hC003, then run -> three consecutive valid cycles A001,B002,C003; then state_o=2, cw_valid_o=0, pc_o=0.
- Load 2 words, step held high 10 cycles -> exactly one valid cycle with word0, pc_o=1. Second step -> word1, state DONE.
- Load DEPTH+1 words -> count_o=8, full_o=1 after 8th. 9th ignored: buffer unchanged, verified by run.
- Load 5 words, run, halt after 2nd issued word -> state IDLE, pc_o=2. run -> words 2,3,4 issued, then DONE.
- Same-cycle clear and run edges with 3 words stored -> count_o=0, no valid cycle. With CW_SEQ_LOOP_EN: 2 words, run 7 cycles -> w0,w1,w0,w1,... until halt.
